// File: rtl/systolic_result_writer.sv
// Collects the eight 128-bit bottom-row output rounds that follow start_check, packs them
// into one result word and writes it to the result SRAM at the address latched with the start.
module systolic_result_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_ROUNDS = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_CASES  = 1024
) (
    input  logic                                  clk,
    input  logic                                  rstSys,
    input  logic                                  start_check,
    input  logic [ADDR_WIDTH-1:0]                 BankAddr,
    input  logic [DATA_WIDTH-1:0]                 OpC30,
    input  logic [DATA_WIDTH-1:0]                 OpC31,
    input  logic [DATA_WIDTH-1:0]                 OpC32,
    input  logic [DATA_WIDTH-1:0]                 OpC33,
    output logic                                  ResCs,
    output logic                                  ResWe,
    output logic [ADDR_WIDTH-1:0]                 ResAddr,
    output logic [NUM_ROUNDS*4*DATA_WIDTH-1:0]    ResDin,
    output logic [$clog2(NUM_CASES+1)-1:0]        WordsWritten,
    output logic                                  AllDone,
    output logic                                  Overrun
);

    localparam int RW     = 4 * DATA_WIDTH;
    localparam int WORD_W = NUM_ROUNDS * RW;
    localparam int RND_W  = $clog2(NUM_ROUNDS);
    localparam int CNT_W  = $clog2(NUM_CASES + 1);

    localparam logic [RND_W-1:0]      LAST_RND  = RND_W'(NUM_ROUNDS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_CASES - 1);
    localparam logic [CNT_W-1:0]      MAX_WORDS = CNT_W'(NUM_CASES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE
    } state_t;

    state_t                  state_reg, state_next;
    logic [RND_W-1:0]        rnd_reg, rnd_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;

    logic                    capture_en;
    logic [RND_W-1:0]        capture_idx;
    logic                    write_fire;
    logic                    word_done;
    logic                    overrun_set;

    logic                    res_cs_reg;
    logic                    res_we_reg;
    logic [ADDR_WIDTH-1:0]   res_addr_reg;
    logic [WORD_W-1:0]       res_din_reg;
    logic [CNT_W-1:0]        words_reg;
    logic                    all_done_reg;
    logic                    overrun_reg;

    logic [RW-1:0]           round_word;
    logic [RW-1:0]           capture_reg [NUM_ROUNDS-1];
    logic [WORD_W-1:0]       packed_word;

    assign round_word = {OpC30, OpC31, OpC32, OpC33};

    // Only rounds 0..NUM_ROUNDS-2 are buffered; the last round goes straight from
    // the input pins into the packed word on the edge that launches the write.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ROUNDS - 1; gi++) begin : g_pack
            assign packed_word[gi*RW +: RW] = capture_reg[gi];
        end
    endgenerate
    assign packed_word[WORD_W-1 -: RW] = round_word;

    always_comb begin
        state_next  = state_reg;
        rnd_next    = rnd_reg;
        addr_next   = addr_reg;
        capture_en  = 1'b0;
        capture_idx = rnd_reg;
        write_fire  = 1'b0;
        word_done   = 1'b0;
        overrun_set = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start_check) begin
                    capture_en  = 1'b1;
                    capture_idx = '0;
                    addr_next   = BankAddr;
                    rnd_next    = RND_W'(1);
                    state_next  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                overrun_set = start_check;
                if (rnd_reg == LAST_RND) begin
                    write_fire = 1'b1;
                    rnd_next   = '0;
                    state_next = ST_WRITE;
                end else begin
                    capture_en = 1'b1;
                    rnd_next   = rnd_reg + RND_W'(1);
                end
            end
            ST_WRITE: begin
                word_done = 1'b1;
                if (start_check) begin
                    capture_en  = 1'b1;
                    capture_idx = '0;
                    addr_next   = BankAddr;
                    rnd_next    = RND_W'(1);
                    state_next  = ST_COLLECT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                rnd_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstSys) begin
            for (int i = 0; i < NUM_ROUNDS - 1; i++) begin
                capture_reg[i] <= '0;
            end
        end else if (capture_en) begin
            capture_reg[capture_idx] <= round_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rstSys) begin
            state_reg    <= ST_IDLE;
            rnd_reg      <= '0;
            addr_reg     <= '0;
            res_cs_reg   <= 1'b0;
            res_we_reg   <= 1'b0;
            res_addr_reg <= '0;
            res_din_reg  <= '0;
            words_reg    <= '0;
            all_done_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rnd_reg    <= rnd_next;
            addr_reg   <= addr_next;
            res_cs_reg <= write_fire;
            res_we_reg <= write_fire;
            if (write_fire) begin
                res_addr_reg <= addr_reg;
                res_din_reg  <= packed_word;
            end
            // The word on the bus during WRITE is the one being retired here.
            if (word_done) begin
                if (words_reg != MAX_WORDS) begin
                    words_reg <= words_reg + CNT_W'(1);
                end
                if (res_addr_reg == LAST_ADDR) begin
                    all_done_reg <= 1'b1;
                end
            end
            if (overrun_set) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign ResCs        = res_cs_reg;
    assign ResWe        = res_we_reg;
    assign ResAddr      = res_addr_reg;
    assign ResDin       = res_din_reg;
    assign WordsWritten = words_reg;
    assign AllDone      = all_done_reg;
    assign Overrun      = overrun_reg;

endmodule

// File: tb/tb_systolic_result_writer.sv
// Randomized bench for systolic_result_writer: a transaction-level model predicts each
// SRAM write (cycle, address, packed word) plus the counter and sticky flags.
module tb_systolic_result_writer;

    logic          clk = 1'b0;
    logic          rstSys = 1'b1;
    logic          start_check = 1'b0;
    logic [9:0]    BankAddr = '0;
    logic [31:0]   OpC30 = '0, OpC31 = '0, OpC32 = '0, OpC33 = '0;
    logic          ResCs, ResWe;
    logic [9:0]    ResAddr;
    logic [1023:0] ResDin;
    logic [10:0]   WordsWritten;
    logic          AllDone, Overrun;

    systolic_result_writer dut (
        .clk          (clk),
        .rstSys       (rstSys),
        .start_check  (start_check),
        .BankAddr     (BankAddr),
        .OpC30        (OpC30),
        .OpC31        (OpC31),
        .OpC32        (OpC32),
        .OpC33        (OpC33),
        .ResCs        (ResCs),
        .ResWe        (ResWe),
        .ResAddr      (ResAddr),
        .ResDin       (ResDin),
        .WordsWritten (WordsWritten),
        .AllDone      (AllDone),
        .Overrun      (Overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int npass = 0;
    int ntotal = 0;

    int            obs_cyc[$];
    logic [9:0]    obs_addr[$];
    logic [1023:0] obs_data[$];
    int            exp_cyc[$];
    logic [9:0]    exp_addr[$];
    logic [1023:0] exp_data[$];

    int exp_words;
    bit exp_alldone;
    bit exp_overrun;

    always @(negedge clk) begin
        ntotal++;
        if (ResCs !== ResWe) $display("FAIL cs_we_pair: ResCs=%b ResWe=%b, need equal", ResCs, ResWe);
        else npass++;
        if (ResWe === 1'b1) begin
            obs_cyc.push_back(cyc);
            obs_addr.push_back(ResAddr);
            obs_data.push_back(ResDin);
            $display("write cyc=%0d addr=%0d lo=%h", cyc, ResAddr, ResDin[127:0]);
        end
    end

    task automatic clear_queues();
        obs_cyc.delete(); obs_addr.delete(); obs_data.delete();
        exp_cyc.delete(); exp_addr.delete(); exp_data.delete();
    endtask

    task automatic model_reset();
        exp_words = 0; exp_alldone = 0; exp_overrun = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start_check = 1'b0;
            BankAddr = 10'($urandom);
            {OpC30, OpC31, OpC32, OpC33} = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
    endtask

    // Eight-cycle case: start on the first cycle, optional stray start at ovr_at,
    // optional reset at rst_at. The expected word is just the rounds laid side by side.
    task automatic drive_case(input logic [9:0] addr, input int ovr_at, input int rst_at,
                              input bit pattern, input bit expect_wr);
        logic [127:0]  r;
        logic [1023:0] word;
        int            t;
        t = cyc;
        for (int k = 0; k < 8; k++) begin
            if (pattern) r = {4{32'(k + 1)}};
            else r = {$urandom, $urandom, $urandom, $urandom};
            word[k*128 +: 128] = r;
            start_check = (k == 0) || (k == ovr_at) || (k == rst_at);
            rstSys = (k == rst_at);
            BankAddr = (k == 0) ? addr : 10'($urandom);
            {OpC30, OpC31, OpC32, OpC33} = r;
            @(posedge clk); #1;
        end
        start_check = 1'b0;
        rstSys = 1'b0;
        if (expect_wr) begin
            exp_cyc.push_back(t + 8);
            exp_addr.push_back(addr);
            exp_data.push_back(word);
            if (exp_words < 1024) exp_words++;
            if (addr == 10'd1023) exp_alldone = 1;
        end
    endtask

    task automatic test_reset();
        rstSys = 1'b1;
        start_check = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rstSys = 1'b0;
        start_check = 1'b0;
        model_reset();
        idle(10);
        ntotal++; if (ResCs !== 1'b0) $display("FAIL reset_cs: got %b need 0", ResCs); else npass++;
        ntotal++; if (ResWe !== 1'b0) $display("FAIL reset_we: got %b need 0", ResWe); else npass++;
        ntotal++; if (ResAddr !== 10'd0) $display("FAIL reset_addr: got %0d need 0", ResAddr); else npass++;
        ntotal++; if (ResDin !== 1024'd0) $display("FAIL reset_din: got lo=%h need 0", ResDin[127:0]); else npass++;
        ntotal++; if (WordsWritten !== 11'd0) $display("FAIL reset_words: got %0d need 0", WordsWritten); else npass++;
        ntotal++; if (AllDone !== 1'b0) $display("FAIL reset_alldone: got %b need 0", AllDone); else npass++;
        ntotal++; if (Overrun !== 1'b0) $display("FAIL reset_overrun: got %b need 0", Overrun); else npass++;
    endtask

    task automatic test_single();
        clear_queues();
        drive_case(10'd5, -1, -1, 1'b1, 1'b1);
        idle(12);
        ntotal++;
        if (obs_cyc.size() != exp_cyc.size())
            $display("FAIL single_count: got %0d writes need %0d", obs_cyc.size(), exp_cyc.size());
        else npass++;
        foreach (exp_cyc[i]) if (i < obs_cyc.size()) begin
            ntotal++;
            if (obs_cyc[i] !== exp_cyc[i] || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL single_write%0d: got cyc=%0d addr=%0d hi=%h lo=%h need cyc=%0d addr=%0d hi=%h lo=%h",
                         i, obs_cyc[i], obs_addr[i], obs_data[i][1023:896], obs_data[i][127:0],
                         exp_cyc[i], exp_addr[i], exp_data[i][1023:896], exp_data[i][127:0]);
            else npass++;
        end
        ntotal++; if (WordsWritten !== 11'(exp_words)) $display("FAIL single_words: got %0d need %0d", WordsWritten, exp_words); else npass++;
        ntotal++; if (Overrun !== exp_overrun) $display("FAIL single_overrun: got %b need %b", Overrun, exp_overrun); else npass++;
    endtask

    task automatic test_back_to_back();
        clear_queues();
        drive_case(10'd5, -1, -1, 1'b0, 1'b1);
        drive_case(10'd6, -1, -1, 1'b0, 1'b1);
        drive_case(10'($urandom_range(0, 1000)), -1, -1, 1'b0, 1'b1);
        drive_case(10'($urandom_range(0, 1000)), -1, -1, 1'b0, 1'b1);
        idle(12);
        ntotal++;
        if (obs_cyc.size() != exp_cyc.size())
            $display("FAIL b2b_count: got %0d writes need %0d", obs_cyc.size(), exp_cyc.size());
        else npass++;
        foreach (exp_cyc[i]) if (i < obs_cyc.size()) begin
            ntotal++;
            if (obs_cyc[i] !== exp_cyc[i] || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL b2b_write%0d: got cyc=%0d addr=%0d hi=%h lo=%h need cyc=%0d addr=%0d hi=%h lo=%h",
                         i, obs_cyc[i], obs_addr[i], obs_data[i][1023:896], obs_data[i][127:0],
                         exp_cyc[i], exp_addr[i], exp_data[i][1023:896], exp_data[i][127:0]);
            else npass++;
        end
        ntotal++; if (WordsWritten !== 11'(exp_words)) $display("FAIL b2b_words: got %0d need %0d", WordsWritten, exp_words); else npass++;
        ntotal++; if (Overrun !== exp_overrun) $display("FAIL b2b_overrun: got %b need %b", Overrun, exp_overrun); else npass++;
    endtask

    task automatic test_overrun();
        clear_queues();
        drive_case(10'($urandom_range(0, 1000)), 3, -1, 1'b0, 1'b1);
        exp_overrun = 1;
        idle(12);
        ntotal++;
        if (obs_cyc.size() != exp_cyc.size())
            $display("FAIL overrun_count: got %0d writes need %0d", obs_cyc.size(), exp_cyc.size());
        else npass++;
        foreach (exp_cyc[i]) if (i < obs_cyc.size()) begin
            ntotal++;
            if (obs_cyc[i] !== exp_cyc[i] || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL overrun_write%0d: got cyc=%0d addr=%0d hi=%h lo=%h need cyc=%0d addr=%0d hi=%h lo=%h",
                         i, obs_cyc[i], obs_addr[i], obs_data[i][1023:896], obs_data[i][127:0],
                         exp_cyc[i], exp_addr[i], exp_data[i][1023:896], exp_data[i][127:0]);
            else npass++;
        end
        ntotal++; if (Overrun !== exp_overrun) $display("FAIL overrun_flag: got %b need %b", Overrun, exp_overrun); else npass++;
        ntotal++; if (WordsWritten !== 11'(exp_words)) $display("FAIL overrun_words: got %0d need %0d", WordsWritten, exp_words); else npass++;
    endtask

    task automatic test_all_done();
        clear_queues();
        drive_case(10'd1023, -1, -1, 1'b0, 1'b1);
        ntotal++; if (ResWe !== 1'b1) $display("FAIL alldone_we_t8: got %b need 1", ResWe); else npass++;
        ntotal++; if (AllDone !== 1'b0) $display("FAIL alldone_t8: got %b need 0", AllDone); else npass++;
        idle(1);
        ntotal++; if (AllDone !== 1'b1) $display("FAIL alldone_t9: got %b need 1", AllDone); else npass++;
        idle(10);
        ntotal++;
        if (obs_cyc.size() != exp_cyc.size())
            $display("FAIL alldone_count: got %0d writes need %0d", obs_cyc.size(), exp_cyc.size());
        else npass++;
        foreach (exp_cyc[i]) if (i < obs_cyc.size()) begin
            ntotal++;
            if (obs_cyc[i] !== exp_cyc[i] || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL alldone_write%0d: got cyc=%0d addr=%0d hi=%h lo=%h need cyc=%0d addr=%0d hi=%h lo=%h",
                         i, obs_cyc[i], obs_addr[i], obs_data[i][1023:896], obs_data[i][127:0],
                         exp_cyc[i], exp_addr[i], exp_data[i][1023:896], exp_data[i][127:0]);
            else npass++;
        end
        ntotal++; if (WordsWritten !== 11'(exp_words)) $display("FAIL alldone_words: got %0d need %0d", WordsWritten, exp_words); else npass++;
        ntotal++; if (Overrun !== exp_overrun) $display("FAIL alldone_overrun: got %b need %b", Overrun, exp_overrun); else npass++;
    endtask

    task automatic test_reset_mid();
        clear_queues();
        drive_case(10'd7, -1, 4, 1'b0, 1'b0);
        model_reset();
        idle(12);
        ntotal++; if (obs_cyc.size() != 0) $display("FAIL rstmid_nowrite: got %0d writes need 0", obs_cyc.size()); else npass++;
        ntotal++; if (ResAddr !== 10'd0 || ResDin !== 1024'd0) $display("FAIL rstmid_bus: got addr=%0d lo=%h need 0", ResAddr, ResDin[127:0]); else npass++;
        ntotal++; if (WordsWritten !== 11'd0) $display("FAIL rstmid_words: got %0d need 0", WordsWritten); else npass++;
        ntotal++; if (AllDone !== 1'b0 || Overrun !== 1'b0) $display("FAIL rstmid_flags: got alldone=%b overrun=%b need 0 0", AllDone, Overrun); else npass++;
        drive_case(10'd5, -1, -1, 1'b1, 1'b1);
        idle(12);
        ntotal++;
        if (obs_cyc.size() != exp_cyc.size())
            $display("FAIL rstmid_count: got %0d writes need %0d", obs_cyc.size(), exp_cyc.size());
        else npass++;
        foreach (exp_cyc[i]) if (i < obs_cyc.size()) begin
            ntotal++;
            if (obs_cyc[i] !== exp_cyc[i] || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL rstmid_write%0d: got cyc=%0d addr=%0d hi=%h lo=%h need cyc=%0d addr=%0d hi=%h lo=%h",
                         i, obs_cyc[i], obs_addr[i], obs_data[i][1023:896], obs_data[i][127:0],
                         exp_cyc[i], exp_addr[i], exp_data[i][1023:896], exp_data[i][127:0]);
            else npass++;
        end
        ntotal++; if (WordsWritten !== 11'(exp_words)) $display("FAIL rstmid_words_after: got %0d need %0d", WordsWritten, exp_words); else npass++;
    endtask

    task automatic test_full_run();
        rstSys = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rstSys = 1'b0;
        model_reset();
        clear_queues();
        for (int i = 0; i < 1024; i++) begin
            drive_case(10'(i), -1, -1, 1'b0, 1'b1);
            idle(9);
        end
        idle(4);
        ntotal++; if (WordsWritten !== 11'd1024) $display("FAIL full_words: got %0d need 1024", WordsWritten); else npass++;
        ntotal++; if (AllDone !== 1'b1) $display("FAIL full_alldone: got %b need 1", AllDone); else npass++;
        ntotal++; if (Overrun !== 1'b0) $display("FAIL full_overrun: got %b need 0", Overrun); else npass++;
        // Writes after completion still land; the counter stays saturated.
        drive_case(10'($urandom_range(0, 1022)), -1, -1, 1'b0, 1'b1);
        drive_case(10'($urandom_range(0, 1022)), -1, -1, 1'b0, 1'b1);
        idle(12);
        ntotal++;
        if (obs_cyc.size() != exp_cyc.size())
            $display("FAIL full_count: got %0d writes need %0d", obs_cyc.size(), exp_cyc.size());
        else npass++;
        foreach (exp_cyc[i]) if (i < obs_cyc.size()) begin
            ntotal++;
            if (obs_cyc[i] !== exp_cyc[i] || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL full_write%0d: got cyc=%0d addr=%0d hi=%h lo=%h need cyc=%0d addr=%0d hi=%h lo=%h",
                         i, obs_cyc[i], obs_addr[i], obs_data[i][1023:896], obs_data[i][127:0],
                         exp_cyc[i], exp_addr[i], exp_data[i][1023:896], exp_data[i][127:0]);
            else npass++;
        end
        ntotal++; if (WordsWritten !== 11'(exp_words)) $display("FAIL full_saturate: got %0d need %0d", WordsWritten, exp_words); else npass++;
        ntotal++; if (AllDone !== 1'b1) $display("FAIL full_alldone_sticky: got %b need 1", AllDone); else npass++;
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_all_done();
        test_reset_mid();
        test_full_run();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
